// File: rtl/multicycle_controller_if.sv
// Memory handshake between the multicycle controller and the shared memory port.
//   MemReq   : controller requests an access this cycle
//   MemWrite : requested access is a store
//   AdrSrc   : address select, 0 = PC, 1 = ALU result register
//   MemReady : memory completes the pending request this cycle
// master = controller side, slave = memory side.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
  modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RISC-V datapath. It sequences
// fetch/decode/execute/memory/writeback through one shared memory port.
// It also keeps a sticky illegal-instruction trap and a retired-instruction counter.
// Optional feature macro: RV_JAL_EN adds the JAL state and J-type ImmSrc.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   Opcode        : instr[6:0] from the instruction register
//   Zero          : ALU zero flag (beq)
//   mem           : memory handshake (MemReq/MemWrite/AdrSrc out, MemReady in)
//   IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp : datapath controls
//   ImmSrc        : immediate format, decoded from Opcode in every state
//   IllegalInstr  : trap flag, held until reset
//   RetireCount   : retired-instruction count, wraps modulo 2^CNT_W
// Outputs are decoded from the registered state. IRWrite and PCWrite also
// follow MemReady in FETCH, so a fetch completes on the edge that transfers.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              Opcode,
  input  logic                    Zero,
  multicycle_controller_if.master mem,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    RegWrite,
  output logic [1:0]              ResultSrc,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              ImmSrc,
  output logic                    IllegalInstr,
  output logic [CNT_W-1:0]        RetireCount
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef RV_JAL_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
`ifdef RV_JAL_EN
    S_JAL,
`endif
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_req, mem_write, adr_src, ir_write, reg_write, illegal;
  logic       pc_update, branch, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  // State and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore decode of the datapath controls
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        ir_write   = mem.MemReady;
        if (mem.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Compute the branch target PC+imm while the opcode is decoded
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef RV_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (Opcode == OP_SW) ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem.MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef RV_JAL_EN
      S_JAL: begin
        // PC <- branch target from DECODE; ALU forms the link value OldPC+4
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`endif
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_START;
    endcase
  end

  // Immediate format follows the IR opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (Opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
`ifdef RV_JAL_EN
      OP_JAL:  ImmSrc = 2'b11;
`endif
      default: ImmSrc = 2'b00;
    endcase
  end

  // Retire on the edge that leaves the final state of an instruction
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                  ((state_q == S_MEMWR) && mem.MemReady);
  assign cnt_d  = cnt_q + CNT_W'(retire);

  assign mem.MemReq   = mem_req;
  assign mem.MemWrite = mem_write;
  assign mem.AdrSrc   = adr_src;
  assign IRWrite      = ir_write;
  // In FETCH the PC advances only with the transferring edge
  assign PCWrite      = (pc_update && ((state_q != S_FETCH) || mem.MemReady)) || (branch && Zero);
  assign RegWrite     = reg_write;
  assign ResultSrc    = result_src;
  assign ALUSrcA      = alu_src_a;
  assign ALUSrcB      = alu_src_b;
  assign ALUOp        = alu_op;
  assign IllegalInstr = illegal;
  assign RetireCount  = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (CNT_W=4 so wrap is reachable).
// The driver pushes the expected per-cycle outputs; the monitor pops and compares on negedge.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [6:0]       Opcode;
  logic             Zero;
  logic             IRWrite, PCWrite, RegWrite, IllegalInstr;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [CNT_W-1:0] RetireCount;

  multicycle_controller_if mif();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Opcode       (Opcode),
    .Zero         (Zero),
    .mem          (mif),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ImmSrc       (ImmSrc),
    .IllegalInstr (IllegalInstr),
    .RetireCount  (RetireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [16:0]      ev;
    logic [CNT_W-1:0] ec;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0]       op_q     = 7'd0;
  logic [1:0]       imm_q    = 2'd0;
  logic [CNT_W-1:0] cnt_e    = '0;
  logic             idle_rdy = 1'b0;

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,IllegalInstr}
  function automatic logic [16:0] v(input int mreq, input int mwr, input int adr, input int irw,
                                    input int pcw, input int rw, input int rs, input int sa,
                                    input int sb, input int aop, input int imm, input int ill);
    return {1'(mreq), 1'(mwr), 1'(adr), 1'(irw), 1'(pcw), 1'(rw),
            2'(rs), 2'(sa), 2'(sb), 2'(aop), 2'(imm), 1'(ill)};
  endfunction

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      logic [16:0] got;
      e   = sb_q.pop_front();
      got = {mif.MemReq, mif.MemWrite, mif.AdrSrc, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalInstr};
      checks++;
      if (got !== e.ev || RetireCount !== e.ec) begin
        failures++;
        $display("FAIL %s: got outs=%b cnt=%0d expected outs=%b cnt=%0d",
                 e.nm, got, RetireCount, e.ev, e.ec);
      end
    end
  end

  task automatic cyc(input string nm, input logic [6:0] op, input logic rdy, input logic z,
                     input logic [16:0] ev);
    @(posedge clk);
    #1;
    Opcode       = op;
    mif.MemReady = rdy;
    Zero         = z;
    sb_q.push_back('{nm: nm, ev: ev, ec: cnt_e});
  endtask

  task automatic t_reset(input string nm);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    mif.MemReady = 1'b0;
    Zero         = 1'b0;
    cnt_e        = '0;
    sb_q.push_back('{nm: nm, ev: v(0,0,0,0,0,0,0,0,0,0,imm_q,0), ec: cnt_e});
  endtask

  task automatic t_release(input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back('{nm: nm, ev: v(0,0,0,0,0,0,0,0,0,0,imm_q,0), ec: cnt_e});
  endtask

  task automatic t_fetch(input string nm, input int waits);
    for (int i = 0; i < waits; i++) cyc(nm, op_q, 1'b0, 1'b0, v(1,0,0,0,0,0,2,0,2,0,imm_q,0));
    cyc(nm, op_q, 1'b1, 1'b0, v(1,0,0,1,1,0,2,0,2,0,imm_q,0));
  endtask

  task automatic t_decode(input string nm, input logic [6:0] op, input logic [1:0] imm);
    op_q  = op;
    imm_q = imm;
    cyc(nm, op, idle_rdy, 1'b0, v(0,0,0,0,0,0,0,1,1,0,imm,0));
  endtask

  task automatic t_memadr(input string nm);
    cyc(nm, op_q, idle_rdy, 1'b0, v(0,0,0,0,0,0,0,2,1,0,imm_q,0));
  endtask

  task automatic t_memread(input string nm, input int waits);
    for (int i = 0; i < waits; i++) cyc(nm, op_q, 1'b0, 1'b0, v(1,0,1,0,0,0,0,0,0,0,imm_q,0));
    cyc(nm, op_q, 1'b1, 1'b0, v(1,0,1,0,0,0,0,0,0,0,imm_q,0));
  endtask

  task automatic t_memwb(input string nm);
    cyc(nm, op_q, idle_rdy, 1'b0, v(0,0,0,0,0,1,1,0,0,0,imm_q,0));
    cnt_e++;
  endtask

  task automatic t_memwr(input string nm, input int waits);
    for (int i = 0; i < waits; i++) cyc(nm, op_q, 1'b0, 1'b0, v(1,1,1,0,0,0,0,0,0,0,imm_q,0));
    cyc(nm, op_q, 1'b1, 1'b0, v(1,1,1,0,0,0,0,0,0,0,imm_q,0));
    cnt_e++;
  endtask

  task automatic t_exec(input string nm, input int srcb);
    cyc(nm, op_q, idle_rdy, 1'b0, v(0,0,0,0,0,0,0,2,srcb,2,imm_q,0));
  endtask

  task automatic t_aluwb(input string nm);
    cyc(nm, op_q, idle_rdy, 1'b0, v(0,0,0,0,0,1,0,0,0,0,imm_q,0));
    cnt_e++;
  endtask

  task automatic t_beq(input string nm, input logic z);
    cyc(nm, op_q, idle_rdy, z, v(0,0,0,0,int'(z),0,0,2,0,1,imm_q,0));
    cnt_e++;
  endtask

  task automatic t_trap(input string nm);
    cyc(nm, op_q, 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,0,0,imm_q,1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    Opcode       = 7'd0;
    Zero         = 1'b0;
    mif.MemReady = 1'b0;

    // Reset state, then lw with memory always ready
    t_reset("reset");
    idle_rdy = 1'b1;
    t_release("lw_start");
    t_fetch("lw_fetch", 0);
    t_decode("lw_decode", 7'b0000011, 2'b00);
    t_memadr("lw_memadr");
    t_memread("lw_memread", 0);
    t_memwb("lw_memwb");

    // sw with three wait states in MEMWR
    idle_rdy = 1'b0;
    t_fetch("sw_fetch", 0);
    t_decode("sw_decode", 7'b0100011, 2'b01);
    t_memadr("sw_memadr");
    t_memwr("sw_memwr", 3);

    // beq taken and not taken
    t_fetch("beq1_fetch", 0);
    t_decode("beq1_decode", 7'b1100011, 2'b10);
    t_beq("beq_taken", 1'b1);
    t_fetch("beq2_fetch", 0);
    t_decode("beq2_decode", 7'b1100011, 2'b10);
    t_beq("beq_not_taken", 1'b0);

    // R-type, then addi with fetch wait states
    t_fetch("r_fetch", 0);
    t_decode("r_decode", 7'b0110011, 2'b00);
    t_exec("r_execr", 0);
    t_aluwb("r_aluwb");
    t_fetch("addi_fetch", 2);
    t_decode("addi_decode", 7'b0010011, 2'b00);
    t_exec("addi_execi", 1);
    t_aluwb("addi_aluwb");

    // Illegal opcode traps; MemReady high must be ignored
    t_fetch("ill_fetch", 0);
    t_decode("ill_decode", 7'b0000000, 2'b00);
    for (int i = 0; i < 20; i++) t_trap("trap_hold");
    t_reset("trap_reset");
    t_release("trap_release");

    // Reset during a MEMREAD wait aborts the access
    t_fetch("abort_fetch0", 0);
    t_decode("abort_decode0", 7'b0010011, 2'b00);
    t_exec("abort_execi", 1);
    t_aluwb("abort_aluwb");
    t_fetch("abort_fetch", 0);
    t_decode("abort_decode", 7'b0000011, 2'b00);
    t_memadr("abort_memadr");
    cyc("abort_wait", op_q, 1'b0, 1'b0, v(1,0,1,0,0,0,0,0,0,0,imm_q,0));
    cyc("abort_wait", op_q, 1'b0, 1'b0, v(1,0,1,0,0,0,0,0,0,0,imm_q,0));
    t_reset("abort_reset");
    t_release("abort_start");
    t_fetch("abort_refetch", 0);

    // 17 addi instructions wrap the 4-bit counter to 1
    t_decode("wrap_decode", 7'b0010011, 2'b00);
    t_exec("wrap_execi", 1);
    t_aluwb("wrap_aluwb");
    for (int i = 0; i < 16; i++) begin
      t_fetch("wrap_fetch", 0);
      t_decode("wrap_decode", 7'b0010011, 2'b00);
      t_exec("wrap_execi", 1);
      t_aluwb("wrap_aluwb");
    end
    t_fetch("wrap_done_fetch", 0);

    // jal: linked through ALUWB when enabled, otherwise illegal
`ifdef RV_JAL_EN
    t_decode("jal_decode", 7'b1101111, 2'b11);
    cyc("jal_jal", op_q, idle_rdy, 1'b0, v(0,0,0,0,1,0,0,1,2,0,imm_q,0));
    t_aluwb("jal_aluwb");
    t_fetch("jal_next_fetch", 0);
`else
    t_decode("jal_decode", 7'b1101111, 2'b00);
    for (int i = 0; i < 3; i++) t_trap("jal_trap");
`endif

    // Drain remaining expectations with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
